// File: rtl/systolic_pkg.sv
// Shared types and semiring helpers for the systolic matrix-multiply engine.
package systolic_pkg;

  typedef enum logic [1:0] {
    MODE_BOOL = 2'd0,
    MODE_MOD  = 2'd1,
    MODE_SAT  = 2'd2,
    MODE_TROP = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_READOUT
  } state_e;

  // Arithmetic is carried at 64 bits; operands and results must fit in 32.
  typedef logic [63:0] wide_t;

  function automatic wide_t sat_limit(input int unsigned w);
    return (wide_t'(1) << w) - wide_t'(1);
  endfunction

  function automatic wide_t sat_add(input wide_t a, input wide_t b, input int unsigned w);
    wide_t s;
    s = a + b;
    return (s > sat_limit(w)) ? sat_limit(w) : s;
  endfunction

  function automatic wide_t sat_mul(input wide_t a, input wide_t b, input int unsigned w);
    wide_t p;
    p = a * b;
    return (p > sat_limit(w)) ? sat_limit(w) : p;
  endfunction

  function automatic wide_t mode_identity(input mode_e m, input int unsigned w);
    return (m == MODE_TROP) ? sat_limit(w) : '0;
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// One systolic cell: valid-tagged operand pass-through, semiring accumulator
// and an upward readout shift path.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int W     = 4,
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic             shift,
  input  mode_e            mode,
  input  logic [W:0]       a_i,
  input  logic [W:0]       b_i,
  input  logic [ACC_W-1:0] acc_i,
  output logic [W:0]       a_o,
  output logic [W:0]       b_o,
  output logic [ACC_W-1:0] acc_o
);

  logic [W:0]       a_d, a_q, b_d, b_q;
  logic [ACC_W-1:0] acc_d, acc_q;
  wide_t            wa, wb, wacc, p;

  always_comb begin
    a_d   = a_i;
    b_d   = b_i;
    acc_d = acc_q;
    wa    = wide_t'(a_i[W-1:0]);
    wb    = wide_t'(b_i[W-1:0]);
    wacc  = wide_t'(acc_q);
    p     = sat_add(wa, wb, ACC_W);
    if (init) begin
      acc_d = ACC_W'(mode_identity(mode, ACC_W));
    end else if (shift) begin
      acc_d = acc_i;
    end else if (a_i[W] && b_i[W]) begin
      case (mode)
        MODE_BOOL: acc_d = acc_q | ACC_W'(a_i[0] & b_i[0]);
        MODE_MOD:  acc_d = ACC_W'(wacc + wa * wb);
        MODE_SAT:  acc_d = ACC_W'(sat_add(wacc, sat_mul(wa, wb, ACC_W), ACC_W));
        MODE_TROP: acc_d = (p < wacc) ? ACC_W'(p) : acc_q;
        default:   acc_d = acc_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end

  assign a_o   = a_q;
  assign b_o   = b_q;
  assign acc_o = acc_q;

endmodule

// File: rtl/systolic_matmul.sv
// N x N systolic matrix multiply: input skew triangles, PE grid, job FSM with
// drain counter and a backpressured row-by-row readout.
module systolic_matmul
  import systolic_pkg::*;
#(
  parameter int N     = 8,
  parameter int W     = 4,
  parameter int ACC_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  input  logic [N*W-1:0]     a_in,
  input  logic [N*W-1:0]     b_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*ACC_W-1:0] out_data,
  output logic               busy,
  output logic               done
);

  localparam int CW = $clog2(2 * N);
  localparam int RW = $clog2(N);

  state_e        state_d, state_q;
  mode_e         mode_d, mode_q, pe_mode;
  logic [CW-1:0] cnt_d, cnt_q;
  logic [RW-1:0] row_d, row_q;
  logic          done_d, done_q;
  logic          init, shift, beat_ok;

  logic [W:0]       a_skew [N];
  logic [W:0]       b_skew [N];
  logic [W:0]       a_out  [N][N];
  logic [W:0]       b_out  [N][N];
  logic [ACC_W-1:0] acc_out [N][N];
  logic [N-1:0]     edge_par;
  logic             unused_edges;

  assign beat_ok = in_valid && (state_q == ST_LOAD);
  assign pe_mode = (state_q == ST_IDLE) ? mode_e'(mode) : mode_q;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    done_d  = 1'b0;
    init    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_LOAD;
        mode_d  = mode_e'(mode);
        init    = 1'b1;
      end
      ST_LOAD: if (in_valid && in_last) begin
        state_d = ST_DRAIN;
        cnt_d   = '0;
      end
      ST_DRAIN: begin
        if (cnt_q == CW'(2 * N - 2)) begin
          state_d = ST_READOUT;
          row_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_READOUT: if (out_ready) begin
        shift = 1'b1;
        if (row_q == RW'(N - 1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_BOOL;
      cnt_q   <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      done_q  <= done_d;
    end
  end

  // Row i of A and column i of B both see an i-deep delay line.
  for (genvar gi = 0; gi < N; gi++) begin : g_skew
    logic [W:0] a_tag, b_tag;
    assign a_tag = beat_ok ? {1'b1, a_in[gi*W +: W]} : '0;
    assign b_tag = beat_ok ? {1'b1, b_in[gi*W +: W]} : '0;
    if (gi == 0) begin : g_direct
      assign a_skew[gi] = a_tag;
      assign b_skew[gi] = b_tag;
    end else begin : g_dly
      logic [W:0] a_dly_d [gi];
      logic [W:0] a_dly_q [gi];
      logic [W:0] b_dly_d [gi];
      logic [W:0] b_dly_q [gi];
      always_comb begin
        a_dly_d[0] = a_tag;
        b_dly_d[0] = b_tag;
        for (int unsigned k = 1; k < gi; k++) begin
          a_dly_d[k] = a_dly_q[k-1];
          b_dly_d[k] = b_dly_q[k-1];
        end
      end
      always_ff @(posedge clk) begin
        if (reset) begin
          a_dly_q <= '{default: '0};
          b_dly_q <= '{default: '0};
        end else begin
          a_dly_q <= a_dly_d;
          b_dly_q <= b_dly_d;
        end
      end
      assign a_skew[gi] = a_dly_q[gi-1];
      assign b_skew[gi] = b_dly_q[gi-1];
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      logic [W:0]       a_src, b_src;
      logic [ACC_W-1:0] acc_src;
      if (gj == 0) begin : g_al
        assign a_src = a_skew[gi];
      end else begin : g_ar
        assign a_src = a_out[gi][gj-1];
      end
      if (gi == 0) begin : g_bt
        assign b_src = b_skew[gj];
      end else begin : g_bb
        assign b_src = b_out[gi-1][gj];
      end
      if (gi == N - 1) begin : g_sb
        assign acc_src = '0;
      end else begin : g_sn
        assign acc_src = acc_out[gi+1][gj];
      end
      systolic_pe #(.W(W), .ACC_W(ACC_W)) u_pe (
        .clk   (clk),
        .reset (reset),
        .init  (init),
        .shift (shift),
        .mode  (pe_mode),
        .a_i   (a_src),
        .b_i   (b_src),
        .acc_i (acc_src),
        .a_o   (a_out[gi][gj]),
        .b_o   (b_out[gi][gj]),
        .acc_o (acc_out[gi][gj])
      );
    end
    assign edge_par[gi] = ^{a_out[gi][N-1], b_out[N-1][gi]};
  end

  assign unused_edges = ^edge_par;

  // Row 0 of the grid is the presented row; readout shifts the grid upward.
  always_comb begin
    out_data = '0;
    if (out_valid) begin
      for (int unsigned j = 0; j < N; j++) begin
        out_data[j*ACC_W +: ACC_W] = acc_out[0][j];
      end
    end
  end

  assign out_valid = (state_q == ST_READOUT);
  assign in_ready  = (state_q == ST_LOAD);
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_systolic_matmul.sv
// Directed self-checking bench for systolic_matmul at N=4, W=4, ACC_W=8.
module tb_systolic_matmul;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int AW = 8;

  logic            clk = 1'b0;
  logic            reset, start, in_valid, in_last, in_ready;
  logic [1:0]      mode;
  logic [N*W-1:0]  a_in, b_in;
  logic            out_valid, out_ready, busy, done;
  logic [N*AW-1:0] out_data;

  int total = 0;
  int bad   = 0;
  int ma [N][N];
  int mb [N][N];
  int mc [N][N];

  always #5 clk = ~clk;

  systolic_matmul #(.N(N), .W(W), .ACC_W(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_beat(input int k);
    for (int i = 0; i < N; i++) begin
      a_in[i*W +: W] = W'(ma[i][k]);
      b_in[i*W +: W] = W'(mb[k][i]);
    end
  endtask

  task automatic fill(input int av, input int bv, input int cv);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        ma[i][j] = av;
        mb[i][j] = bv;
        mc[i][j] = cv;
      end
    end
  endtask

  task automatic run_job(input logic [1:0] md, input int kb, input bit bub, input bit bp,
                         input string tag);
    int n;
    logic [N*AW-1:0] held;
    mode  = md;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val({tag, " busy_after_start"}, 64'(busy), 64'd1);
    check_val({tag, " in_ready_after_start"}, 64'(in_ready), 64'd1);
    if (bub) mode = ~md;
    for (int k = 0; k < kb; k++) begin
      set_beat(k);
      in_valid = 1'b1;
      in_last  = (k == kb - 1);
      tick();
      if (bub && k < kb - 1) begin
        in_valid = 1'b0;
        in_last  = 1'b1;
        a_in     = (N*W)'($urandom);
        b_in     = (N*W)'($urandom);
        start    = 1'b1;
        mode     = 2'd0;
        tick();
        start    = 1'b0;
      end
    end
    in_last = 1'b0;
    if (bub) begin
      in_valid = 1'b1;
      in_last  = 1'b1;
      a_in     = '1;
      b_in     = '1;
      start    = 1'b1;
    end else begin
      in_valid = 1'b0;
    end
    n = 0;
    while (!out_valid && n < 64) begin
      tick();
      n++;
    end
    start = 1'b0;
    check_val({tag, " drain_latency"}, 64'(n), 64'(2 * N - 1));
    check_val({tag, " in_ready_readout"}, 64'(in_ready), 64'd0);
    for (int r = 0; r < N; r++) begin
      if (bp) begin
        out_ready = 1'b0;
        held = out_data;
        tick();
        tick();
        check_val($sformatf("%s hold_row%0d", tag, r), 64'(out_data == held), 64'd1);
      end
      out_ready = 1'b1;
      check_val($sformatf("%s valid_row%0d", tag, r), 64'(out_valid), 64'd1);
      for (int j = 0; j < N; j++) begin
        check_val($sformatf("%s C[%0d][%0d]", tag, r, j),
                  64'(out_data[j*AW +: AW]), 64'(mc[r][j]));
      end
      tick();
    end
    check_val({tag, " done_pulse"}, 64'(done), 64'd1);
    check_val({tag, " busy_fall"}, 64'(busy), 64'd0);
    in_valid = 1'b0;
    in_last  = 1'b0;
    tick();
    check_val({tag, " done_clear"}, 64'(done), 64'd0);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    mode      = 2'd0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    a_in      = '0;
    b_in      = '0;
    out_ready = 1'b1;
    tick();
    tick();
    check_val("rst in_ready", 64'(in_ready), 64'd0);
    check_val("rst out_valid", 64'(out_valid), 64'd0);
    check_val("rst out_data", 64'(out_data), 64'd0);
    check_val("rst busy", 64'(busy), 64'd0);
    check_val("rst done", 64'(done), 64'd0);
    reset = 1'b0;
    tick();

    // Beats offered while idle must be discarded.
    in_valid = 1'b1;
    a_in     = '1;
    b_in     = '1;
    tick();

    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        ma[i][j] = (i == j) ? 1 : 0;
        mb[i][j] = (i == j) ? 1 : 0;
        mc[i][j] = (i == j) ? 1 : 0;
      end
    end
    run_job(2'd0, 4, 1'b0, 1'b0, "bool");

    fill(15, 15, 132);
    run_job(2'd1, 4, 1'b0, 1'b0, "mod15");

    fill(15, 15, 255);
    run_job(2'd2, 4, 1'b0, 1'b0, "sat15");

    fill(3, 3, 9);
    run_job(2'd2, 1, 1'b0, 1'b0, "sat_k1");

    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        ma[i][j] = 1;
        mb[i][j] = i + j + 2;
        mc[i][j] = j + 3;
      end
    end
    run_job(2'd3, 4, 1'b0, 1'b0, "trop");

    fill(15, 15, 30);
    run_job(2'd3, 1, 1'b0, 1'b0, "trop_k1");

    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        ma[i][j] = i + 1;
        mb[i][j] = i + j;
        mc[i][j] = (i + 1) * (6 + 4 * j);
      end
    end
    run_job(2'd1, 4, 1'b0, 1'b0, "mod_pat");
    run_job(2'd1, 4, 1'b1, 1'b1, "mod_bub");

    fill(15, 15, 132);
    mode  = 2'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < N; k++) begin
      set_beat(k);
      in_valid = 1'b1;
      in_last  = (k == N - 1);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    tick();
    tick();
    check_val("abort busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_val("abort busy", 64'(busy), 64'd0);
    check_val("abort in_ready", 64'(in_ready), 64'd0);
    check_val("abort out_valid", 64'(out_valid), 64'd0);
    check_val("abort out_data", 64'(out_data), 64'd0);
    check_val("abort done", 64'(done), 64'd0);
    tick();

    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        ma[i][j] = (i == j) ? 1 : 0;
        mb[i][j] = (i == j) ? 1 : 0;
        mc[i][j] = (i == j) ? 1 : 0;
      end
    end
    run_job(2'd0, 4, 1'b0, 1'b0, "bool_after_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
